palette_fade_ctrl: RTL and testbench

//  Sequences the 16-entry palette lookup between the sprite/background index source and the VGA colour outputs.

---
 rtl/palette_fade_ctrl_if.sv | 25 ++
 rtl/palette_fade_ctrl.sv | 148 ++++++++++++++
 tb/tb_palette_fade_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/palette_fade_ctrl_if.sv
// Pixel-in, palette lookup and scaled-colour-out signals of the palette fade controller.
// The master drives pixels and palette data; the slave is the controller.
interface palette_fade_ctrl_if;
    logic       pix_valid;
    logic [3:0] pix_index;
    logic [3:0] pal_index;
    logic [3:0] pal_red;
    logic [3:0] pal_green;
    logic [3:0] pal_blue;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       rgb_valid;
    logic       transparent;

    modport master (
        output pix_valid, pix_index, pal_red, pal_green, pal_blue,
        input  pal_index, red, green, blue, rgb_valid, transparent
    );

    modport slave (
        input  pix_valid, pix_index, pal_red, pal_green, pal_blue,
        output pal_index, red, green, blue, rgb_valid, transparent
    );
endinterface

// File: rtl/palette_fade_ctrl.sv
// Two-stage palette lookup pipeline with global brightness scaling, plus a
// frame-synchronous fade FSM that steps the brightness level between black and full.
module palette_fade_ctrl #(
    parameter int unsigned FramesPerStep  = 2,
    parameter logic [3:0]  TransparentIdx = 4'h3,
    parameter int unsigned MaxLevel       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic                fade_out_req,
    input  logic                fade_in_req,
    palette_fade_ctrl_if.slave  bus,
    output logic [4:0]          level,
    output logic                busy,
    output logic                done
);

    localparam int unsigned      CntW     = (FramesPerStep > 1) ? $clog2(FramesPerStep) : 1;
    localparam logic [CntW-1:0]  CntLast  = CntW'(FramesPerStep - 1);
    localparam logic [4:0]       LevelMax = 5'(MaxLevel);

    typedef enum logic [1:0] {StIdle, StFadeOut, StDark, StFadeIn} state_e;

    state_e          state_q, state_d;
    logic [4:0]      level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;

    // ------------------------------------------------------------------
    // Fade FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            level_q <= LevelMax;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // fade_out_req has priority over a simultaneous fade_in_req
                if (fade_out_req) begin
                    state_d = StFadeOut;
                    cnt_d   = '0;
                end
            end
            StFadeOut: begin
                if (frame_start) begin
                    if (cnt_q == CntLast) begin
                        cnt_d   = '0;
                        level_d = level_q - 5'd1;
                        if (level_q == 5'd1) begin
                            state_d = StDark;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDark: begin
                if (fade_in_req) begin
                    state_d = StFadeIn;
                    cnt_d   = '0;
                end
            end
            StFadeIn: begin
                if (frame_start) begin
                    if (cnt_q == CntLast) begin
                        cnt_d   = '0;
                        level_d = level_q + 5'd1;
                        if (level_q == LevelMax - 5'd1) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    assign level = level_q;
    assign busy  = (state_q == StFadeOut) || (state_q == StFadeIn);
    assign done  = done_q;

    // ------------------------------------------------------------------
    // Pixel pipeline
    // ------------------------------------------------------------------
    logic [3:0] pal_index_q;
    logic       s1_valid_q, s1_transp_q;
    logic [3:0] red_q, green_q, blue_q;
    logic       rgb_valid_q, transparent_q;
    logic [3:0] red_s, green_s, blue_s;

    // Product is 4b x 5b; bits [7:4] of the product are the scaled channel.
    always_comb begin
        red_s   = 4'(({5'b0, bus.pal_red}   * {4'b0, level_q}) >> 4);
        green_s = 4'(({5'b0, bus.pal_green} * {4'b0, level_q}) >> 4);
        blue_s  = 4'(({5'b0, bus.pal_blue}  * {4'b0, level_q}) >> 4);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pal_index_q   <= '0;
            s1_valid_q    <= 1'b0;
            s1_transp_q   <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            rgb_valid_q   <= 1'b0;
            transparent_q <= 1'b0;
        end else begin
            if (bus.pix_valid) begin
                pal_index_q <= bus.pix_index;
            end
            s1_valid_q    <= bus.pix_valid;
            s1_transp_q   <= bus.pix_valid && (bus.pix_index == TransparentIdx);
            rgb_valid_q   <= s1_valid_q;
            transparent_q <= s1_transp_q;
            red_q         <= s1_valid_q ? red_s   : 4'h0;
            green_q       <= s1_valid_q ? green_s : 4'h0;
            blue_q        <= s1_valid_q ? blue_s  : 4'h0;
        end
    end

    assign bus.pal_index   = pal_index_q;
    assign bus.red         = red_q;
    assign bus.green       = green_q;
    assign bus.blue        = blue_q;
    assign bus.rgb_valid   = rgb_valid_q;
    assign bus.transparent = transparent_q;

endmodule

// File: tb/tb_palette_fade_ctrl.sv
// Randomized scoreboard bench for palette_fade_ctrl: a frame-count based fade model
// predicts level/busy/done, and expected colours are queued for an independent monitor.
module tb_palette_fade_ctrl;

    localparam int unsigned Fps = 2;
    localparam logic [11:0] PAL [16] = '{
        12'h000, 12'h00F, 12'hCCA, 12'h123, 12'hF0F, 12'h5A5, 12'hFFF, 12'h888,
        12'h71E, 12'h3C9, 12'hA0B, 12'h4D2, 12'hE6F, 12'h097, 12'hB48, 12'h6E1
    };

    typedef struct {
        logic [11:0] rgb;
        logic        tr;
        int          stamp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       fs, ro, ri;
    logic [4:0] level;
    logic       busy, done;
    logic [11:0] pal_word;

    palette_fade_ctrl_if bus ();

    palette_fade_ctrl #(
        .FramesPerStep  (Fps),
        .TransparentIdx (4'h3),
        .MaxLevel       (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (fs),
        .fade_out_req (ro),
        .fade_in_req  (ri),
        .bus          (bus),
        .level        (level),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Combinational palette ROM answering the registered index
    assign pal_word      = PAL[bus.pal_index];
    assign bus.pal_red   = pal_word[11:8];
    assign bus.pal_green = pal_word[7:4];
    assign bus.pal_blue  = pal_word[3:0];

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sbq[$];
    exp_t mon_e;

    // Reference state: fade progress expressed as frames seen since the fade began
    int         m_level, m_mode, m_frames;
    logic [3:0] m_pal;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [11:0] scale(input logic [11:0] c, input int l);
        int r, g, b;
        r = (int'(c[11:8]) * l) / 16;
        g = (int'(c[7:4])  * l) / 16;
        b = (int'(c[3:0])  * l) / 16;
        return {4'(r), 4'(g), 4'(b)};
    endfunction

    task automatic model_reset();
        m_level  = 16;
        m_mode   = 0;
        m_frames = 0;
        m_pal    = 4'h0;
    endtask

    // One clock of stimulus; modes 0 idle, 1 fading out, 2 dark, 3 fading in
    task automatic step(input bit f, input bit o, input bit i, input bit pv, input logic [3:0] px);
        int   stamp;
        bit   exp_done;
        exp_t e;
        fs = f;
        ro = o;
        ri = i;
        bus.pix_valid = pv;
        bus.pix_index = px;
        stamp = cyc;
        @(posedge clk);
        #1;
        fs = 1'b0;
        ro = 1'b0;
        ri = 1'b0;
        bus.pix_valid = 1'b0;
        exp_done = 1'b0;
        case (m_mode)
            0: if (o) begin m_mode = 1; m_frames = 0; end
            1: if (f) begin
                m_frames++;
                m_level = 16 - m_frames / Fps;
                if (m_level == 0) begin m_mode = 2; exp_done = 1'b1; end
            end
            2: if (i) begin m_mode = 3; m_frames = 0; end
            default: if (f) begin
                m_frames++;
                m_level = m_frames / Fps;
                if (m_level == 16) begin m_mode = 0; exp_done = 1'b1; end
            end
        endcase
        if (pv) begin
            m_pal   = px;
            e.rgb   = scale(PAL[px], m_level);
            e.tr    = (px == 4'h3);
            e.stamp = stamp;
            sbq.push_back(e);
        end
        chk("level", 32'(level), 32'(m_level));
        chk("busy", 32'(busy), 32'(m_mode == 1 || m_mode == 3));
        chk("done", 32'(done), 32'(exp_done));
        chk("pal_index", 32'(bus.pal_index), 32'(m_pal));
    endtask

    task automatic rand_step(input bit f, input bit o, input bit i);
        step(f, o, i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    endtask

    // Monitor: every valid colour must match the oldest queued expectation, 2 cycles after issue
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.rgb_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rgb_valid", 32'd1, 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("rgb", 32'({bus.red, bus.green, bus.blue}), 32'(mon_e.rgb));
                    chk("transparent", 32'(bus.transparent), 32'(mon_e.tr));
                    chk("latency", 32'(cyc - mon_e.stamp), 32'd2);
                end
            end else begin
                chk("idle_rgb_zero", 32'({bus.red, bus.green, bus.blue, bus.transparent}), 32'd0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        fs = 1'b0;
        ro = 1'b0;
        ri = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_index = 4'h0;
        model_reset();
        #12;
        chk("rst_level", 32'(level), 32'd16);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pal_index", 32'(bus.pal_index), 32'd0);
        chk("rst_rgb_valid", 32'(bus.rgb_valid), 32'd0);
        chk("rst_rgb", 32'({bus.red, bus.green, bus.blue, bus.transparent}), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Single pixel at full brightness, then transparent / non-transparent indices
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'h2);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'h3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'h4);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        repeat (20) rand_step(1'b0, 1'b0, 1'b0);

        // Ignored fade_in in IDLE, then simultaneous requests start a fade-out
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'h2);

        for (int k = 0; k < 32; k++) begin
            step(1'b1, k == 10, k == 12, 1'b1, 4'h2);
            repeat ($urandom_range(1, 3)) rand_step(1'b0, k == 5, 1'b0);
        end

        // Dark: colours black while still valid
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'h2);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'h6);
        repeat (4) rand_step(1'b1, 1'b0, 1'b0);

        // fade_in_req coincident with frame_start: that frame is not counted
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'h2);
        for (int k = 0; k < 18; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) rand_step(1'b0, 1'b1, 1'b1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'h2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

        // Asynchronous reset between edges at level 9 with a pixel in flight
        chk("pre_reset_level", 32'(level), 32'd9);
        #1 rst = 1'b1;
        sbq.delete();
        model_reset();
        #1;
        chk("arst_level", 32'(level), 32'd16);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_rgb_valid", 32'(bus.rgb_valid), 32'd0);
        chk("arst_pal_index", 32'(bus.pal_index), 32'd0);
        chk("arst_rgb", 32'({bus.red, bus.green, bus.blue, bus.transparent}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;

        // Complete fade-out followed by complete fade-in back to IDLE
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        for (int k = 0; k < 32; k++) begin
            rand_step(1'b1, 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) rand_step(1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        for (int k = 0; k < 32; k++) begin
            rand_step(1'b1, 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) rand_step(1'b0, 1'b0, 1'b0);
        end
        repeat (4) rand_step(1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
